// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU (AND/OR/XOR/ADD) through an
// IDLE -> EXEC -> RESP handshake. Accept in IDLE, compute in EXEC, hold the
// result in RESP until the consumer takes it.
// Optional feature: define ALU_ARBITER_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prefer0;
  logic             accept;

  logic [1:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             id_p0;

  logic [WIDTH-1:0] data_p1;
  logic             id_p1;

  // Shared ALU; ADD wraps modulo 2^WIDTH (carry out discarded).
  function automatic logic [WIDTH-1:0] alu_calc(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = a & b;
      2'b01:   res = a | b;
      2'b10:   res = a ^ b;
      default: res = a + b;
    endcase
    return res;
  endfunction

`ifdef ALU_ARBITER_RR_EN
  logic last_grant;

  // Remember who was granted last; reset points at requester 1 so that
  // requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= req1_ready;
    end
  end

  assign prefer0 = last_grant;
`else
  assign prefer0 = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and one-hot grant; readies only ever come from IDLE.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (req0_valid && (!req1_valid || prefer0)) begin
            req0_ready = 1'b1;
            state_nxt  = EXEC;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            state_nxt  = EXEC;
          end
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  // ---- stage p0: capture the granted request ----
  // Operands are captured only on accept, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= req1_ready ? req1_op : req0_op;
      a_p0  <= req1_ready ? req1_a  : req0_a;
      b_p0  <= req1_ready ? req1_b  : req0_b;
      id_p0 <= req1_ready;
    end
  end

  // ---- stage p1: ALU result, held through RESP ----
  // Result and owner register at the end of EXEC and stay put otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      id_p1   <= 1'b0;
    end else if (state == EXEC) begin
      data_p1 <= alu_calc(op_p0, a_p0, b_p0);
      id_p1   <= id_p0;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = data_p1;
  assign rsp_id    = id_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus hand-written sequences for
// contention order, response back-pressure and reset during EXEC.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;
    tick();
  endtask

  // Single request with rsp_ready high; called at posedge+1 with DUT in IDLE.
  task automatic run_vec(input vec_t v, input int k);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end
    @(negedge clk);
    chk($sformatf("v%0d_grant", k), {30'd0, req1_ready, req0_ready},
        v.id ? 32'd2 : 32'd1);
    tick();
    // Scramble inputs after accept; the in-flight operation must not see them.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_op = ~req0_op; req0_a = ~req0_a; req0_b = req0_b + 32'd3;
    req1_op = ~req1_op; req1_a = ~req1_a; req1_b = req1_b + 32'd5;
    @(negedge clk);
    chk($sformatf("v%0d_exec_quiet", k), {29'd0, rsp_valid, req1_ready, req0_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_rsp_data", k), rsp_data, v.exp);
    chk($sformatf("v%0d_rsp_id", k), {31'd0, rsp_id}, {31'd0, v.id});
    tick();
  endtask

  initial begin
    logic [3:0] exp_order;
    logic       g;
    logic       found;

    vecs[0] = '{1'b0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
    vecs[1] = '{1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[2] = '{1'b0, 2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
    vecs[3] = '{1'b0, 2'b11, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[4] = '{1'b1, 2'b10, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0};
    vecs[5] = '{1'b1, 2'b01, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[6] = '{1'b0, 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
    vecs[7] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001};

`ifdef ALU_ARBITER_RR_EN
    exp_order = 4'b1010;  // bit k = expected grant of operation k: 0,1,0,1
`else
    exp_order = 4'b0000;
`endif

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    do_reset();

    // Contention: both requesters valid for four operations.
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h100; req0_b = 32'h1;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h200; req1_b = 32'h2;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) found = 1'b1;
      end
      chk($sformatf("rr%0d_grant_seen", k), {31'd0, found}, 32'd1);
      chk($sformatf("rr%0d_onehot", k), {31'd0, req0_ready & req1_ready}, 32'd0);
      g = req1_ready;
      chk($sformatf("rr%0d_order", k), {31'd0, g}, {31'd0, exp_order[k]});
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
        @(negedge clk);
        if (rsp_valid) found = 1'b1;
      end
      chk($sformatf("rr%0d_rsp_seen", k), {31'd0, found}, 32'd1);
      chk($sformatf("rr%0d_rsp_id", k), {31'd0, rsp_id}, {31'd0, g});
      chk($sformatf("rr%0d_rsp_data", k), rsp_data, g ? 32'h202 : 32'h101);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Directed vector table, single requester at a time.
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], k);
    end

    // Back-pressure: result held for 5 cycles with rsp_ready low.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'hAAAA_AAAA; req0_b = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("bp_grant0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_a = 32'h0; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_exec_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_data", i), rsp_data, 32'h5555_5555);
      chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
      chk($sformatf("bp%0d_readys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      req0_a = $urandom;
      req0_op = 2'($urandom_range(0, 3));
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1234_5678;
    @(negedge clk);
    chk("bp_take_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_take_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_grant1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_next_data", rsp_data, 32'h1234_5678);
    chk("bp_next_id", {31'd0, rsp_id}, 32'd1);
    tick();

    // Reset asserted while an operation from requester 0 is in EXEC.
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h1; req0_b = 32'h1;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rx_exec_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rx_rsp_data", rsp_data, 32'd0);
    chk("rx_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rx_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h00F0; req0_b = 32'h000F;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h10;   req1_b = 32'h10;
    #1;
    chk("rx_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rx_rsp_data_after", rsp_data, 32'h0000_00FF);
    chk("rx_rsp_id_after", {31'd0, rsp_id}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
